// File: rtl/tx_frame_scheduler.sv
// Two-requester round-robin frame scheduler feeding a byte-paced encoder.
// Parses the PHR length, paces bytes at BYTE_PERIOD and spaces frames by IFS_CYCLES.
module tx_frame_scheduler #(
    parameter int BYTE_PERIOD = 8,
    parameter int IFS_CYCLES  = 96
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] phr_psdu_out,
    output logic       phr_psdu_out_valid,
    output logic [1:0] grant,
    output logic       busy,
    output logic       frame_done
);

    localparam int PW = (BYTE_PERIOD > 1) ? $clog2(BYTE_PERIOD) : 1;
    localparam int GW = (IFS_CYCLES > 0) ? $clog2(IFS_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PACE_ONE  = (BYTE_PERIOD > 1) ? PW'(1) : '0;
    localparam logic [PW-1:0] PACE_LAST = PW'(BYTE_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(IFS_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          last_served;
    logic [PW-1:0] pace_cnt;
    logic [6:0]    remaining;
    logic          phr_pending;
    logic [GW-1:0] gap_cnt;

    logic          sel_valid;
    logic [7:0]    sel_data;
    logic          xfer;
    logic          last_byte;
    logic          gap_done;
    logic          req_any;
    logic [1:0]    arb_grant;

    // last_served == 1 means requester 1 went last, so requester 0 wins a tie.
    always_comb begin
        sel_valid = (grant[0] & req0_valid) | (grant[1] & req1_valid);
        sel_data  = grant[1] ? req1_data : req0_data;
        req_any   = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            arb_grant = last_served ? 2'b01 : 2'b10;
        end else if (req0_valid) begin
            arb_grant = 2'b01;
        end else if (req1_valid) begin
            arb_grant = 2'b10;
        end else begin
            arb_grant = 2'b00;
        end
    end

    assign xfer      = (state == SEND) && (pace_cnt == '0) && sel_valid;
    assign last_byte = phr_pending ? (sel_data[6:0] == 7'd0) : (remaining == 7'd1);
    assign gap_done  = (gap_cnt == GAP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_any) next_state = SEND;
            SEND:    if (xfer && last_byte) next_state = GAP;
            GAP:     if (gap_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (state == SEND) && grant[0] && (pace_cnt == '0);
        req1_ready = (state == SEND) && grant[1] && (pace_cnt == '0);
        busy       = (state != IDLE);
    end

    // The GAP count starts on the strobe cycle of the last byte, so busy covers it plus IFS_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant              <= '0;
            last_served        <= 1'b1;
            pace_cnt           <= '0;
            remaining          <= '0;
            phr_pending        <= 1'b0;
            gap_cnt            <= '0;
            phr_psdu_out       <= '0;
            phr_psdu_out_valid <= 1'b0;
            frame_done         <= 1'b0;
        end else begin
            phr_psdu_out_valid <= xfer;
            frame_done         <= xfer && last_byte;
            if (xfer) begin
                phr_psdu_out <= sel_data;
            end
            case (state)
                IDLE: begin
                    if (req_any) begin
                        grant       <= arb_grant;
                        pace_cnt    <= '0;
                        phr_pending <= 1'b1;
                        gap_cnt     <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        phr_pending <= 1'b0;
                        remaining   <= phr_pending ? sel_data[6:0] : remaining - 7'd1;
                        if (last_byte) begin
                            grant       <= '0;
                            last_served <= grant[1];
                            pace_cnt    <= '0;
                            gap_cnt     <= '0;
                        end else begin
                            pace_cnt <= PACE_ONE;
                        end
                    end else if (pace_cnt != '0) begin
                        pace_cnt <= (pace_cnt == PACE_LAST) ? '0 : pace_cnt + PW'(1);
                    end
                end
                GAP: begin
                    if (!gap_done) begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed self-checking bench for tx_frame_scheduler: queued requester
// drivers, a strobe recorder, and one task per scenario.
module tb_tx_frame_scheduler;

    localparam int BP  = 8;
    localparam int IFS = 96;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] phr_psdu_out;
    logic       phr_psdu_out_valid;
    logic [1:0] grant;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_cnt = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       hold0 = 1'b0;
    logic       hold1 = 1'b0;
    logic       took0 = 1'b0;
    logic       took1 = 1'b0;

    logic [7:0] sd[$];
    int         sc[$];
    logic       sf[$];
    logic [1:0] sg[$];

    tx_frame_scheduler #(
        .BYTE_PERIOD(BP),
        .IFS_CYCLES (IFS)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req0_data         (req0_data),
        .req0_valid        (req0_valid),
        .req0_ready        (req0_ready),
        .req1_data         (req1_data),
        .req1_valid        (req1_valid),
        .req1_ready        (req1_ready),
        .phr_psdu_out      (phr_psdu_out),
        .phr_psdu_out_valid(phr_psdu_out_valid),
        .grant             (grant),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes and drive each requester from its byte queue on the falling edge.
    initial begin : drive_and_record
        forever begin
            @(negedge clk);
            if (phr_psdu_out_valid) begin
                sd.push_back(phr_psdu_out);
                sc.push_back(cyc);
                sf.push_back(frame_done);
                sg.push_back(grant);
            end
            if (frame_done) fd_cnt++;
            if (took0 && q0.size() > 0) void'(q0.pop_front());
            if (took1 && q1.size() > 0) void'(q1.pop_front());
            if (!hold0 && q0.size() > 0) begin
                req0_valid = 1'b1;
                req0_data  = q0[0];
            end else begin
                req0_valid = 1'b0;
            end
            if (!hold1 && q1.size() > 0) begin
                req1_valid = 1'b1;
                req1_data  = q1[0];
            end else begin
                req1_valid = 1'b0;
            end
            took0 = reset_n && req0_valid && req0_ready;
            took1 = reset_n && req1_valid && req1_ready;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        hold0 = 1'b0;
        hold1 = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        #1;
        sd.delete();
        sc.delete();
        sf.delete();
        sg.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b expected 000", {req0_ready, req1_ready, busy});
        end
        checks++;
        if ({phr_psdu_out_valid, frame_done, grant} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_status got %b expected 0000", {phr_psdu_out_valid, frame_done, grant});
        end
        checks++;
        if (phr_psdu_out !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h expected 00", phr_psdu_out);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if ({busy, grant} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL idle_no_request got %b expected 000", {busy, grant});
        end
    endtask

    task automatic test_single_frame();
        int n;
        int bcnt;
        logic [7:0] exp[4] = '{8'h03, 8'h11, 8'h22, 8'h33};
        do_reset();
        q0 = '{8'h03, 8'h11, 8'h22, 8'h33};
        reset_n = 1'b1;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL single_grant got %b expected 01", grant);
        end
        n = 0;
        while (sd.size() < 4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sd.size() != 4) begin
            errors++;
            $display("[TB] FAIL single_strobe_count got %0d expected 4", sd.size());
        end
        checks++;
        if ({frame_done, grant, busy} !== 4'b1001) begin
            errors++;
            $display("[TB] FAIL single_end_state got %b expected 1001", {frame_done, grant, busy});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sd[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL single_data%0d got %h expected %h", i, sd[i], exp[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sc[i+1] - sc[i] != BP) begin
                errors++;
                $display("[TB] FAIL single_spacing%0d got %0d expected %0d", i, sc[i+1] - sc[i], BP);
            end
        end
        checks++;
        if ((sf[0] | sf[1] | sf[2]) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early_done got %b expected 0", sf[0] | sf[1] | sf[2]);
        end
        bcnt = 0;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            #1;
            n++;
            if (busy) bcnt++;
            else break;
        end
        checks++;
        if (bcnt != IFS) begin
            errors++;
            $display("[TB] FAIL single_gap_len got %0d expected %0d", bcnt, IFS);
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        q0 = '{8'h01, 8'hA0, 8'h01, 8'hC0};
        q1 = '{8'h01, 8'hB0, 8'h01, 8'hD0};
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        while (sd.size() < 8 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sd.size() != 8) begin
            errors++;
            $display("[TB] FAIL rr_strobe_count got %0d expected 8", sd.size());
        end
        checks++;
        if ({sd[1], sd[3], sd[5], sd[7]} !== 32'hA0B0C0D0) begin
            errors++;
            $display("[TB] FAIL rr_order got %h expected a0b0c0d0", {sd[1], sd[3], sd[5], sd[7]});
        end
        checks++;
        if ({sg[0], sg[2], sg[4], sg[6]} !== 8'b01_10_01_10) begin
            errors++;
            $display("[TB] FAIL rr_grants got %b expected 01100110", {sg[0], sg[2], sg[4], sg[6]});
        end
        checks++;
        if (sg[1] !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rr_grant_clear got %b expected 00", sg[1]);
        end
    endtask

    task automatic test_zero_length();
        int n;
        do_reset();
        q0 = '{8'h80};
        reset_n = 1'b1;
        n = 0;
        while (sd.size() < 1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sd[0] !== 8'h80) begin
            errors++;
            $display("[TB] FAIL zero_data got %h expected 80", sd[0]);
        end
        checks++;
        if ({frame_done, busy, grant, req0_ready} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL zero_state got %b expected 11000", {frame_done, busy, grant, req0_ready});
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (sd.size() != 1) begin
            errors++;
            $display("[TB] FAIL zero_extra_strobe got %0d expected 1", sd.size());
        end
    endtask

    task automatic test_stall();
        int n;
        int rdy;
        logic [7:0] exp[5] = '{8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        do_reset();
        q1 = '{8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        reset_n = 1'b1;
        n = 0;
        while (sd.size() < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        hold1 = 1'b1;
        rdy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (req1_ready) rdy++;
        end
        checks++;
        if (sd.size() != 2) begin
            errors++;
            $display("[TB] FAIL stall_strobes got %0d expected 2", sd.size());
        end
        checks++;
        if (rdy != 14 || req1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_ready got %0d/%b expected 14/1", rdy, req1_ready);
        end
        hold1 = 1'b0;
        n = 0;
        while (sd.size() < 5 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sd.size() != 5) begin
            errors++;
            $display("[TB] FAIL stall_strobe_count got %0d expected 5", sd.size());
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sd[i] !== exp[i]) begin
                errors++;
                $display("[TB] FAIL stall_data%0d got %h expected %h", i, sd[i], exp[i]);
            end
        end
        checks++;
        if (sc[2] - sc[1] != 22 || sc[3] - sc[2] != BP) begin
            errors++;
            $display("[TB] FAIL stall_spacing got %0d,%0d expected 22,%0d", sc[2] - sc[1], sc[3] - sc[2], BP);
        end
        checks++;
        if (sf[4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_done got %b expected 1", sf[4]);
        end
    endtask

    task automatic test_reset_mid_send();
        int n;
        int fd_before;
        do_reset();
        q0 = '{8'h05, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
        reset_n = 1'b1;
        n = 0;
        while (sd.size() < 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        fd_before = fd_cnt;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({phr_psdu_out_valid, phr_psdu_out, grant, busy, req0_ready} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got %h expected 0000",
                     {phr_psdu_out_valid, phr_psdu_out, grant, busy, req0_ready});
        end
        q0.delete();
        q1 = '{8'h02, 8'hC1, 8'hC2};
        repeat (2) @(negedge clk);
        #1;
        sd.delete();
        sc.delete();
        sf.delete();
        sg.delete();
        reset_n = 1'b1;
        n = 0;
        while (sd.size() < 3 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if ({sd[0], sd[1], sd[2]} !== 24'h02C1C2) begin
            errors++;
            $display("[TB] FAIL restart_data got %h expected 02c1c2", {sd[0], sd[1], sd[2]});
        end
        checks++;
        if (sg[0] !== 2'b10) begin
            errors++;
            $display("[TB] FAIL restart_grant got %b expected 10", sg[0]);
        end
        checks++;
        if (fd_cnt != fd_before + 1) begin
            errors++;
            $display("[TB] FAIL restart_done_count got %0d expected %0d", fd_cnt, fd_before + 1);
        end
    endtask

    task automatic test_no_preempt();
        int n;
        int viol;
        do_reset();
        q0 = '{8'h02, 8'hD1, 8'hD2};
        reset_n = 1'b1;
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        q1 = '{8'h01, 8'hE1};
        viol = 0;
        n = 0;
        while (busy && n < 400) begin
            if (req1_ready || grant == 2'b10) viol++;
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (viol != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL preempt_blocked got %0d/%b expected 0/0", viol, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({grant, req1_ready} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL preempt_next_grant got %b expected 101", {grant, req1_ready});
        end
        n = 0;
        while (sd.size() < 5 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if ({sd[0], sd[1], sd[2], sd[3], sd[4]} !== 40'h02D1D201E1) begin
            errors++;
            $display("[TB] FAIL preempt_order got %h expected 02d1d201e1",
                     {sd[0], sd[1], sd[2], sd[3], sd[4]});
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_zero_length();
        test_stall();
        test_reset_mid_send();
        test_no_preempt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 Parameter BYTE_PERIOD, default 8: minimum clk cycles between consecutive bytes issued to the encoding chain (serializer rate).
REQ-002 Parameter IFS_CYCLES, default 96: idle clk cycles inserted after each frame.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk (input, 1) and reset_n (input, 1).
REQ-004 req0_data  input  8  frame bytes from requester 0; first byte is the PHR.
REQ-005 req0_valid  input  1  req0_data holds a valid byte.
REQ-006 req0_ready  output  1  byte accepted when req0_valid & req0_ready.
REQ-007 req1_data / req1_valid / req1_ready  input 8 / input 1 / output 1  same as requester 0.
REQ-008 phr_psdu_out  output  8  byte to the framing_encoding phr_psdu_in.
REQ-009 phr_psdu_out_valid  output  1  one-cycle strobe qualifying phr_psdu_out.
REQ-010 grant  output  2  one-hot owner of the current frame; 2'b00 when no frame is in progress.
REQ-011 busy  output  1  high in SEND or GAP.
REQ-012 frame_done  output  1  one-cycle pulse after the last byte of a frame is transferred.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SEND and GAP.
REQ-014 IDLE: when any req*_valid=1, latch grant by round-robin, go to SEND and clear pace_cnt to 0; with no valid input, stay in IDLE.
REQ-015 Round-robin: when both are valid, grant the requester not served last; after reset, requester 0 has priority; last-served pointer updates at frame end.
REQ-016 req*_ready SHALL be driven only from registered state: 1 only for the granted requester, in SEND, with pace_cnt==0; otherwise 0 (no combinational valid-to-ready path).
REQ-017 Transfer cycle (ready & valid): register the data into phr_psdu_out and pulse phr_psdu_out_valid on the next cycle (latency 1); set pace_cnt to 1.
REQ-018 pace_cnt SHALL count 1..BYTE_PERIOD-1, then wrap to 0; consecutive transfers are therefore at least BYTE_PERIOD cycles apart.
REQ-019 Stall: if valid=0 while pace_cnt==0, pace_cnt holds at 0 and ready stays high until valid returns; no byte is emitted and there is no timeout.
REQ-020 The first transfer of a frame is the PHR: remaining = data[6:0] (0..127); bit 7 is forwarded unmodified and ignored for length.
REQ-021 Each PSDU transfer decrements remaining.
REQ-022 The last byte is the transfer where remaining==0 after the PHR, or the PHR itself when the length is 0.
REQ-023 On the last byte: next state GAP, frame_done pulses on the same cycle as the last phr_psdu_out_valid, and grant clears to 2'b00.
REQ-024 GAP: count IFS_CYCLES cycles starting from the cycle after the last byte is emitted, then return to IDLE; requests are ignored (ready=0) during GAP.
REQ-025 Arbitration is per frame: the granted requester keeps the grant through all 1+length bytes regardless of the other requester's valid.
REQ-026 phr_psdu_out SHALL hold its last value between strobes; phr_psdu_out_valid never exceeds 1 cycle per byte.
REQ-027 Counter widths: remaining 7 bits, pace_cnt ceil(log2(BYTE_PERIOD)), gap counter ceil(log2(IFS_CYCLES+1)); no wrap occurs beyond the stated ranges.

Reset
REQ-028 reset_n=0 SHALL asynchronously force: state IDLE; all outputs 0; pace_cnt, remaining and gap counter 0; round-robin pointer set so requester 0 is preferred.
REQ-029 Reset during SEND or GAP SHALL abandon the frame with no frame_done; the first frame after reset release restarts from its PHR.
REQ-030 After reset_n deasserts, arbitration SHALL occur no earlier than the first rising clk edge.

Verification
REQ-031 req0 frame PHR=8'h03, then 11,22,33, with valid held -> 4 out strobes 8 cycles apart with data 03,11,22,33; frame_done with the 4th strobe; busy stays high 96 more cycles, then IDLE.
REQ-032 req0 and req1 both valid from reset, each with PHR=8'h01 -> req0 frame first; then after the gap req1 is granted; with both valid again, req0 is granted next.
REQ-033 PHR=8'h80 (length 0) -> single strobe of 8'h80, frame_done on the same cycle, then GAP.
REQ-034 req1 drops valid for 20 cycles after byte 2 of a PHR=8'h04 frame -> ready held high, no strobe during the stall, resume with the next byte, total 5 strobes.
REQ-035 Assert reset_n=0 mid-SEND on byte 2 -> all outputs 0 immediately; after release, a new req1 frame is granted and its PHR is emitted correctly.
REQ-036 req1 asserts valid during a req0 frame -> req1_ready stays 0 until req0's gap ends.
